// File: rtl/io_debounce_scheduler_if.sv
// Board-input bundle for io_debounce_scheduler: enable and raw inputs in,
// debounced levels, edge pulses and scan-wrap strobe out.
interface io_debounce_scheduler_if #(
  parameter int p_CHANNELS = 4
);
  logic                  iw_enable;
  logic [p_CHANNELS-1:0] iwv_input;
  logic [p_CHANNELS-1:0] owv_state;
  logic [p_CHANNELS-1:0] owv_rise;
  logic [p_CHANNELS-1:0] owv_fall;
  logic                  ow_scan_wrap;

  modport master (
    output iw_enable, iwv_input,
    input  owv_state, owv_rise, owv_fall, ow_scan_wrap
  );

  modport slave (
    input  iw_enable, iwv_input,
    output owv_state, owv_rise, owv_fall, ow_scan_wrap
  );
endinterface

// File: rtl/io_debounce_scheduler.sv
// Synchronises raw inputs and debounces them with one shared evaluator scanned round-robin.
// Flip latency p_SYNC_DEPTH + slot wait + (p_STABLE_TICKS-1)*p_CHANNELS*p_SCAN_DIV; no backpressure, iw_enable freezes scanning.
module io_debounce_scheduler #(
  parameter int       p_CHANNELS     = 4,
  parameter int       p_SYNC_DEPTH   = 2,
  parameter int       p_SCAN_DIV     = 16,
  parameter int       p_STABLE_TICKS = 8,
  parameter bit [0:0] p_INIT_VALUE   = 1'b0
) (
  input logic                    iw_clk,
  input logic                    iw_rst_n,
  io_debounce_scheduler_if.slave bus
);
  localparam int CW = $clog2(p_STABLE_TICKS + 1);
  localparam int PW = (p_SCAN_DIV > 1) ? $clog2(p_SCAN_DIV) : 1;
  localparam int IW = (p_CHANNELS > 1) ? $clog2(p_CHANNELS) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q [p_CHANNELS];
  logic [CW-1:0]         cnt_d [p_CHANNELS];
  logic [p_CHANNELS-1:0] level_q, level_d;
  logic [p_CHANNELS-1:0] rise_q, rise_d;
  logic [p_CHANNELS-1:0] fall_q, fall_d;
  logic                  wrap_q, wrap_d;

  // The sync chain is deliberately left out of reset so it keeps tracking the pins.
  logic [p_SYNC_DEPTH-1:0][p_CHANNELS-1:0] sync_q, sync_d;
  logic [p_CHANNELS-1:0]                   synced;

  logic          tick;
  logic          sel_sync;
  logic          sel_level;
  logic [CW-1:0] sel_cnt;

  assign sync_d = {sync_q[p_SYNC_DEPTH-2:0], bus.iwv_input};
  assign synced = sync_q[p_SYNC_DEPTH-1];

  always_ff @(posedge iw_clk) begin
    sync_q <= sync_d;
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    rise_d    = '0;
    fall_d    = '0;
    wrap_d    = 1'b0;
    tick      = 1'b0;
    sel_sync  = synced[ptr_q];
    sel_level = level_q[ptr_q];
    sel_cnt   = cnt_q[ptr_q];

    case (state_q)
      ST_IDLE: begin
        if (bus.iw_enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!bus.iw_enable) begin
          state_d = ST_IDLE;
        end else begin
          tick    = (presc_q == PW'(p_SCAN_DIV - 1));
          presc_d = tick ? '0 : presc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only the channel under the pointer is touched, through one shared compare/increment.
    if (tick) begin
      if (sel_sync == sel_level) begin
        cnt_d[ptr_q] = '0;
      end else if (sel_cnt == CW'(p_STABLE_TICKS - 1)) begin
        level_d[ptr_q] = sel_sync;
        cnt_d[ptr_q]   = '0;
        rise_d[ptr_q]  = sel_sync;
        fall_d[ptr_q]  = ~sel_sync;
      end else begin
        cnt_d[ptr_q] = sel_cnt + 1'b1;
      end
      wrap_d = (ptr_q == IW'(p_CHANNELS - 1));
      ptr_d  = wrap_d ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q <= ST_SCAN;
      presc_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '{default: '0};
      level_q <= {p_CHANNELS{p_INIT_VALUE[0]}};
      rise_q  <= '0;
      fall_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.owv_state    = level_q;
  assign bus.owv_rise     = rise_q;
  assign bus.owv_fall     = fall_q;
  assign bus.ow_scan_wrap = wrap_q;
endmodule

// File: tb/tb_io_debounce_scheduler.sv
// Randomised and directed bench for io_debounce_scheduler against a cycle-count reference model.
module tb_io_debounce_scheduler;
  localparam int CH = 4, DIV = 4, STB = 3, DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  io_debounce_scheduler_if #(.p_CHANNELS(CH)) bus ();

  io_debounce_scheduler #(
    .p_CHANNELS(CH), .p_SYNC_DEPTH(DEPTH), .p_SCAN_DIV(DIV),
    .p_STABLE_TICKS(STB), .p_INIT_VALUE(1'b0)
  ) dut (
    .iw_clk  (clk),
    .iw_rst_n(rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: scan position derived from counts of enabled cycles and ticks.
  int          act_cnt = 0, tick_cnt = 0;
  bit          scan_m = 1'b1;
  int          cnt_m [CH] = '{default: 0};
  logic [CH-1:0] st_m = '0, rise_m = '0, fall_m = '0;
  logic          wrap_m = 1'b0;
  logic [CH-1:0] sq [$];
  logic [CH-1:0] m_s;
  int            m_c;
  bit            m_act, m_tick;

  always @(posedge clk) begin
    m_s = sq.pop_front();
    sq.push_back(bus.iwv_input);
    if (!rst_n) begin
      act_cnt = 0; tick_cnt = 0; scan_m = 1'b1;
      cnt_m = '{default: 0};
      st_m = '0; rise_m = '0; fall_m = '0; wrap_m = 1'b0;
    end else begin
      rise_m = '0; fall_m = '0; wrap_m = 1'b0;
      m_act  = bus.iw_enable && scan_m;
      scan_m = bus.iw_enable;
      m_tick = 1'b0;
      if (m_act) begin
        m_tick = (act_cnt % DIV) == DIV - 1;
        act_cnt++;
      end
      if (m_tick) begin
        m_c = tick_cnt % CH;
        tick_cnt++;
        if (m_s[m_c] == st_m[m_c]) cnt_m[m_c] = 0;
        else if (cnt_m[m_c] == STB - 1) begin
          st_m[m_c] = m_s[m_c];
          cnt_m[m_c] = 0;
          if (m_s[m_c]) rise_m[m_c] = 1'b1; else fall_m[m_c] = 1'b1;
        end else cnt_m[m_c]++;
        if (m_c == CH - 1) wrap_m = 1'b1;
      end
    end
  end

  wire [4*CH:0] dut_vec = {bus.owv_state, bus.owv_rise, bus.owv_fall, bus.ow_scan_wrap};
  wire [4*CH:0] mdl_vec = {st_m, rise_m, fall_m, 1'b0, wrap_m};
  wire [3*CH:0] dut_out = {bus.owv_state, bus.owv_rise, bus.owv_fall, bus.ow_scan_wrap};
  wire [3*CH:0] mdl_out = {st_m, rise_m, fall_m, wrap_m};

  task automatic test_reset();
    int w1 = -1, w2 = -1;
    rst_n = 1'b0; bus.iw_enable = 1'b1; bus.iwv_input = '0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (dut_out !== '0) begin
        failures++; $display("FAIL reset_outputs got=%h want=0", dut_out);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_out !== mdl_out) begin
        failures++; $display("FAIL reset_model k=%0d got=%h want=%h", k, dut_out, mdl_out);
      end
      if (bus.ow_scan_wrap === 1'b1) begin
        if (w1 < 0) w1 = k; else if (w2 < 0) w2 = k;
      end
    end
    checks++;
    if (w1 != 16 || w2 != 32) begin
      failures++; $display("FAIL reset_wrap_timing got=%0d,%0d want=16,32", w1, w2);
    end
  endtask

  task automatic test_single_rise();
    int rises = 0, falls = 0;
    @(negedge clk); bus.iwv_input[2] = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_out !== mdl_out) begin
        failures++; $display("FAIL rise_model k=%0d got=%h want=%h", k, dut_out, mdl_out);
      end
      rises += $countones(bus.owv_rise);
      falls += $countones(bus.owv_fall);
    end
    checks++;
    if (rises != 1 || falls != 0 || bus.owv_state !== 4'b0100) begin
      failures++;
      $display("FAIL rise_single got rises=%0d falls=%0d state=%b want 1 0 0100", rises, falls, bus.owv_state);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int g = 0; g < 2; g++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      @(negedge clk); bus.iwv_input[1] = 1'b1;
      repeat (20) @(negedge clk);
      bus.iwv_input[1] = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(posedge clk); #1;
        checks++;
        if (dut_out !== mdl_out) begin
          failures++; $display("FAIL glitch_model k=%0d got=%h want=%h", k, dut_out, mdl_out);
        end
        pulses += bus.owv_rise[1] + bus.owv_fall[1];
      end
    end
    checks++;
    if (pulses != 0 || bus.owv_state[1] !== 1'b0) begin
      failures++; $display("FAIL glitch_noflip got pulses=%0d state1=%b want 0 0", pulses, bus.owv_state[1]);
    end
  endtask

  task automatic test_all_rise();
    int t [CH] = '{default: -1};
    int n [CH] = '{default: 0};
    @(negedge clk); bus.iwv_input = '0;
    repeat (80) @(posedge clk);
    @(negedge clk); bus.iwv_input = '1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_out !== mdl_out || $countones(bus.owv_rise | bus.owv_fall) > 1) begin
        failures++; $display("FAIL allrise_model k=%0d got=%h want=%h", k, dut_out, mdl_out);
      end
      for (int c = 0; c < CH; c++)
        if (bus.owv_rise[c]) begin n[c]++; t[c] = k; end
    end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (n[c] != 1 || !((t[(c+1)%CH] - t[c] == DIV) || (t[(c+1)%CH] - t[c] == DIV - CH*DIV))) begin
        failures++;
        $display("FAIL allrise_order ch%0d got n=%0d gap=%0d want n=1 gap=4", c, n[c], t[(c+1)%CH] - t[c]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    bit found = 1'b0;
    int wrap_k = -1, fall_k = -1, bad = 0;
    logic [CH-1:0] held;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (tick_cnt % CH == 2 && act_cnt % DIV == 1) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL freeze_find got=timeout want=ptr2"); end
    bus.iw_enable = 1'b0; bus.iwv_input[3] = 1'b0; held = st_m;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.owv_rise !== '0 || bus.owv_fall !== '0 || bus.ow_scan_wrap !== 1'b0 || bus.owv_state !== held) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL freeze_quiet got bad=%0d want=0", bad); end
    @(negedge clk); bus.iw_enable = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_out !== mdl_out) begin
        failures++; $display("FAIL freeze_model k=%0d got=%h want=%h", k, dut_out, mdl_out);
      end
      if (bus.ow_scan_wrap === 1'b1 && wrap_k < 0) wrap_k = k;
      if (bus.owv_fall[3] === 1'b1 && fall_k < 0) fall_k = k;
    end
    checks++;
    if (wrap_k != 8 || fall_k != 40) begin
      failures++; $display("FAIL freeze_resume got wrap=%0d fall3=%0d want 8 40", wrap_k, fall_k);
    end
  endtask

  task automatic test_reset_midcount();
    bit found = 1'b0;
    int rise_k = -1;
    @(negedge clk); rst_n = 1'b0; bus.iwv_input = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    bus.iwv_input[0] = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (cnt_m[0] == 2) found = 1'b1;
    end
    checks++;
    if (!found || bus.owv_state !== '0) begin
      failures++; $display("FAIL midcount_setup got found=%0d state=%b want 1 0000", found, bus.owv_state);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_out !== mdl_out) begin
        failures++; $display("FAIL midcount_model k=%0d got=%h want=%h", k, dut_out, mdl_out);
      end
      if (bus.owv_rise[0] === 1'b1 && rise_k < 0) rise_k = k;
    end
    checks++;
    if (rise_k != 36) begin failures++; $display("FAIL midcount_flip got=%0d want=36", rise_k); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) bus.iwv_input[$urandom_range(0, CH-1)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) bus.iw_enable = ~bus.iw_enable;
      else if (!bus.iw_enable && $urandom_range(0, 9) == 0) bus.iw_enable = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut_out !== mdl_out || $countones(bus.owv_rise | bus.owv_fall) > 1) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL random_model k=%0d got=%h want=%h", k, dut_out, mdl_out);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sq.push_back('0);
    bus.iw_enable = 1'b1;
    bus.iwv_input = '0;
    test_reset();
    test_single_rise();
    test_glitch();
    test_all_rise();
    test_enable_freeze();
    test_reset_midcount();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
